// File: rtl/pipelined_adder_pkg.sv
// Shared constants and parameter helpers for the pipelined ripple adder.
package pipelined_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_LANE  = 4;

  // Returns 0 when the width cannot be split into whole lanes; callers treat 0 as illegal.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned lane);
    if (lane == 0 || width == 0 || (width % lane) != 0) begin
      return 0;
    end
    return width / lane;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; master drives operands and consumer ready.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             overflow_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output a_in, b_in, carry_in, valid_in, ready_in,
    input  ready_out, sum_out, carry_out, overflow_out, valid_out
  );

  modport slave (
    input  a_in, b_in, carry_in, valid_in, ready_in,
    output ready_out, sum_out, carry_out, overflow_out, valid_out
  );

endinterface

// File: rtl/pipelined_adder_add_lane.sv
// Combinational LANE-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module add_lane
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned LANE = DEFAULT_LANE
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic            carry_in,
  output logic [LANE-1:0] sum,
  output logic            carry_out,
  output logic            carry_msb
);

  logic [LANE:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = carry_in;
    for (int unsigned i = 0; i < LANE; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign carry_out = carry[LANE];
  assign carry_msb = carry[LANE-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one LANE-bit slice per stage, carry rippled between stages,
// operand skew on the way in and sum deskew on the way out, globally stalled valid/ready.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned LANE  = DEFAULT_LANE
) (
  input logic              clk_in,
  input logic              rst_n_in,
  pipelined_adder_if.slave bus
);

  localparam int unsigned NUM_STAGES = num_stages(WIDTH, LANE);

  if (NUM_STAGES == 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH (%0d) must be a non-zero multiple of LANE (%0d)", WIDTH, LANE);
  end

  // Single enable for the whole pipe; bubbles travel along rather than being squeezed out.
  logic advance;
  assign advance       = !bus.valid_out || bus.ready_in;
  assign bus.ready_out = rst_n_in && advance;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int unsigned SRC_W  = WIDTH - k * LANE;
    localparam int unsigned DONE_W = (k + 1) * LANE;

    logic [SRC_W-1:0]  src_a;
    logic [SRC_W-1:0]  src_b;
    logic              src_c;
    logic              src_v;
    logic [LANE-1:0]   lane_sum;
    logic              lane_cout;
    logic              lane_cmsb;
    logic [DONE_W-1:0] done_sum;

    // src_a/src_b hold only the lanes not yet added; their low lane is this stage's slice.
    if (k == 0) begin : g_src
      assign src_a    = bus.a_in;
      assign src_b    = bus.b_in;
      assign src_c    = bus.carry_in;
      assign src_v    = bus.valid_in;
      assign done_sum = lane_sum;
    end else begin : g_src
      assign src_a    = g_stage[k-1].g_reg.a_rem_q;
      assign src_b    = g_stage[k-1].g_reg.b_rem_q;
      assign src_c    = g_stage[k-1].g_reg.c_q;
      assign src_v    = g_stage[k-1].g_reg.v_q;
      assign done_sum = {lane_sum, g_stage[k-1].g_reg.s_q};
    end

    add_lane #(
      .LANE(LANE)
    ) u_add_lane (
      .a        (src_a[LANE-1:0]),
      .b        (src_b[LANE-1:0]),
      .carry_in (src_c),
      .sum      (lane_sum),
      .carry_out(lane_cout),
      .carry_msb(lane_cmsb)
    );

    if (k < NUM_STAGES - 1) begin : g_reg
      logic                  v_q;
      logic                  c_q;
      logic [SRC_W-LANE-1:0] a_rem_q;
      logic [SRC_W-LANE-1:0] b_rem_q;
      logic [DONE_W-1:0]     s_q;

      // Only the top lane's MSB carry matters for signed overflow.
      logic unused_msb_carry;
      assign unused_msb_carry = lane_cmsb;

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          v_q     <= 1'b0;
          c_q     <= 1'b0;
          a_rem_q <= '0;
          b_rem_q <= '0;
          s_q     <= '0;
        end else if (advance) begin
          v_q <= src_v;
          if (src_v) begin
            c_q     <= lane_cout;
            a_rem_q <= src_a[SRC_W-1:LANE];
            b_rem_q <= src_b[SRC_W-1:LANE];
            s_q     <= done_sum;
          end
        end
      end
    end else begin : g_out
      // Data registers load only with a valid result so they hold across bubbles.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          bus.valid_out    <= 1'b0;
          bus.sum_out      <= '0;
          bus.carry_out    <= 1'b0;
          bus.overflow_out <= 1'b0;
        end else if (advance) begin
          bus.valid_out <= src_v;
          if (src_v) begin
            bus.sum_out      <= done_sum;
            bus.carry_out    <= lane_cout;
            bus.overflow_out <= lane_cout ^ lane_cmsb;
          end
        end
      end
    end
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's single-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in, LANE bits per pipeline stage, with carry rippled stage to stage.
- Valid/ready handshake on input and output; full throughput of one operation per cycle.
- Sits between operand producers and result consumers in FPGA datapaths where a wide single-cycle ripple adder misses timing.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of LANE, otherwise elaboration error.
- LANE, 4, bits added per pipeline stage.
- NUM_STAGES, WIDTH/LANE, derived (localparam); pipeline depth and latency.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0.
- valid_in  input  1  operands valid.
- ready_out  output  1  block accepts operands this cycle.
- sum_out  output  WIDTH  (a_in + b_in + carry_in) mod 2^WIDTH.
- carry_out  output  1  carry out of bit WIDTH-1.
- overflow_out  output  1  two's-complement overflow.
- valid_out  output  1  result valid.
- ready_in  input  1  consumer accepts result.

Behaviour:
- Reset (rst_n_in low, asynchronous) clears all stage valid bits, skew registers, sum_out, carry_out and overflow_out to 0.
- While reset is held, ready_out = 0.
- advance = !valid_out | ready_in. The enable is global: every stage shifts together on advance, and none shifts otherwise. Bubbles are not collapsed.
- ready_out = advance, combinational from ready_in. There is no combinational path from valid_in to any output.
- Accept: valid_in & ready_out at a rising edge.
- Stage k (0..NUM_STAGES-1) adds lane k of A and B, bits [k*LANE +: LANE], plus the carry registered from stage k-1; stage 0 uses carry_in.
- Upper-lane operand bits travel through input skew registers. Completed lower-lane sum bits travel through output deskew registers, so the full result emerges aligned.
- Latency: a result is presented exactly NUM_STAGES rising edges after acceptance, provided no stalls occur.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Stalled output (valid_out & !ready_in): sum_out, carry_out, overflow_out and valid_out stay stable, and no stage moves.
- overflow_out = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered alongside the sum.
- Wrap-around: 0xFFFF + 0x0001 gives sum 0x0000 with carry_out = 1 (WIDTH = 16).
- Simultaneous accept and output handshake in one cycle is legal and keeps full throughput.
- Reset mid-operation discards all in-flight operations. valid_out falls asynchronously with rst_n_in, and no stale result appears after release.
- When valid_out = 0, output data registers hold their last values. Consumers must ignore them.

Decomposition:
- Shared package pipelined_adder_pkg: default WIDTH/LANE constants, and a function computing NUM_STAGES with a divisibility check.
- Sub-module add_lane: combinational LANE-bit ripple adder with carry in, carry out, and carry into its MSB (needed for overflow). Instantiated once per stage via generate.
- Top level holds all registers, skew/deskew logic and the handshake.

Test Plan (WIDTH = 16, LANE = 4, latency 4):
- Reset: rst_n_in low, valid_in = 1, a_in = 0x1234 -> valid_out = 0, sum_out = 0, ready_out = 0. After release with ready_in = 1 -> ready_out = 1.
- Single operations:
  - a = 0x00FF, b = 0x0001, cin = 0 -> 4 cycles later sum 0x0100, carry 0, ovf 0.
  - a = 0, b = 0, cin = 1 -> sum 0x0001.
- Full-width carry ripple and overflow:
  - 0xFFFF + 0x0001 -> sum 0x0000, carry 1, ovf 0.
  - 0x7FFF + 0x0001 -> sum 0x8000, carry 0, ovf 1.
  - 0x8000 + 0x8000 -> sum 0x0000, carry 1, ovf 1.
- Streaming: 8 back-to-back random ops with ready_in = 1 -> 8 correct results on consecutive cycles, starting 4 cycles after the first accept, in order.
- Backpressure: ready_in = 0 for 3 cycles while valid_out = 1 with 4 ops in flight -> outputs frozen and ready_out = 0. After resume, all 4 results are correct, in order, with none duplicated.
- Async reset mid-flight: rst_n_in pulses low between clock edges with 3 ops in flight -> valid_out = 0 immediately. After release, no result appears until new operands are accepted, and the next op returns the correct sum after 4 cycles.
